weight_buffer_loader: RTL and testbench

//  Upstream feeder for the weight buffer. Accepts a stream of dataWidth-bit weight words
//  (valid/ready) and packs psys consecutive words into one dataWidth*psys row.

---
 rtl/weight_buffer_loader.sv | 150 +++++++++++++++
 tb/tb_weight_buffer_loader.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_buffer_loader.sv
// Weight buffer loader: packs psys weight words into one buffer row and writes rows in order.
// Optional running checksum of accepted words, enabled by WEIGHT_LOADER_CHECKSUM_EN.
module weight_buffer_loader #(
    parameter int dataWidth    = 32,
    parameter int featureLen   = 256,
    parameter int psys         = 24,
    parameter int addressWidth = $clog2(featureLen*featureLen/psys)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [addressWidth-1:0]   num_rows,
    input  logic                      in_valid,
    input  logic [dataWidth-1:0]      in_data,
    output logic                      in_ready,
    output logic                      wr_en,
    output logic [addressWidth-1:0]   wr_addr,
    output logic [dataWidth*psys-1:0] wr_data,
    output logic                      busy,
    output logic                      done,
    output logic [dataWidth-1:0]      checksum
);

    localparam int LW = (psys > 1) ? $clog2(psys) : 1;
    localparam logic [LW-1:0] LANE_LAST = LW'(psys - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                      state_q, state_d;
    logic [LW-1:0]               lane_q, lane_d;
    logic [addressWidth-1:0]     row_q, row_d;
    logic [addressWidth-1:0]     nrows_q, nrows_d;
    logic [dataWidth*psys-1:0]   pack_q, pack_d;
    logic                        wr_en_q, wr_en_d;
    logic [addressWidth-1:0]     wr_addr_q, wr_addr_d;
    logic [dataWidth*psys-1:0]   wr_data_q, wr_data_d;
    logic                        done_q;
    logic                        accept;
    logic                        start_acc;

    assign in_ready  = (state_q == LOAD);
    assign accept    = in_valid && in_ready;
    assign start_acc = start && (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign done      = done_q;

    // Next-state logic: lane packing, row write issue and load sequencing
    always_comb begin
        state_d   = state_q;
        lane_d    = lane_q;
        row_d     = row_q;
        nrows_d   = nrows_q;
        pack_d    = pack_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    nrows_d = num_rows;
                    row_d   = '0;
                    lane_d  = '0;
                    state_d = (num_rows == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (accept) begin
                    pack_d[lane_q*dataWidth +: dataWidth] = in_data;
                    if (lane_q == LANE_LAST) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = row_q;
                        wr_data_d = pack_d;
                        lane_d    = '0;
                        if (row_q == nrows_q - addressWidth'(1)) begin
                            state_d = DONE;
                        end else begin
                            row_d = row_q + addressWidth'(1);
                        end
                    end else begin
                        lane_d = lane_q + LW'(1);
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any partial row
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            lane_q    <= '0;
            row_q     <= '0;
            nrows_q   <= '0;
            pack_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            lane_q    <= lane_d;
            row_q     <= row_d;
            nrows_q   <= nrows_d;
            pack_q    <= pack_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= (state_q == DONE);
        end
    end

`ifdef WEIGHT_LOADER_CHECKSUM_EN
    logic [dataWidth-1:0] sum_q, sum_d;

    // Running sum of accepted words, restarted by each accepted start
    always_comb begin
        sum_d = sum_q;
        if (start_acc) begin
            sum_d = '0;
        end else if (accept) begin
            sum_d = sum_q + in_data;
        end
    end

    // Checksum register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign checksum = sum_q;
`else
    logic unused_start_acc;
    assign unused_start_acc = start_acc;
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_weight_buffer_loader.sv
// Self-checking bench for weight_buffer_loader.
// Expected row writes go to a scoreboard queue and are popped as wr_en appears.
module tb_weight_buffer_loader;

    localparam int DW = 32;
    localparam int PS = 24;
    localparam int AW = 12;

    typedef struct packed {
        logic [AW-1:0]    a;
        logic [DW*PS-1:0] d;
    } wr_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [AW-1:0]    num_rows = '0;
    logic             in_valid = 1'b0;
    logic [DW-1:0]    in_data = '0;
    logic             in_ready;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [DW*PS-1:0] wr_data;
    logic             busy;
    logic             done;
    logic [DW-1:0]    checksum;

    int n_checks = 0;
    int n_fails  = 0;

    wr_t           exp_q[$];
    logic [DW-1:0] words[$];
    logic [DW-1:0] exp_sum;

    weight_buffer_loader dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .num_rows (num_rows),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done),
        .checksum (checksum)
    );

    always #5 clk = ~clk;

    // mode 0: words k+1 per row, 1: random, 2: all ones
    task automatic run_load(input int rows, input int mode, input int gap,
                            input bit poke);
        logic [DW*PS-1:0] row;
        logic [DW-1:0] w;
        int budget;
        int nwr;
        int cyc;
        int last_wr;
        bit saw_done;
        wr_t e;
        words.delete();
        exp_q.delete();
        exp_sum = '0;
        for (int r = 0; r < rows; r++) begin
            row = '0;
            for (int k = 0; k < PS; k++) begin
                w = (mode == 0) ? DW'(k + 1) :
                    (mode == 1) ? DW'($urandom) : '1;
                words.push_back(w);
                row[k*DW +: DW] = w;
                exp_sum = exp_sum + w;
            end
            e.a = AW'(r);
            e.d = row;
            exp_q.push_back(e);
        end
        budget = rows * PS * 4 + 40;
        @(posedge clk); #1;
        start = 1'b1;
        num_rows = AW'(rows);
        @(posedge clk); #1;
        start = 1'b0;
        nwr = 0;
        saw_done = 1'b0;
        last_wr = -10;
        fork
            begin
                int idx;
                int t;
                bit acc;
                idx = 0;
                t = 0;
                while (idx < words.size() && t < budget) begin
                    in_valid = ($urandom_range(0, 99) >= gap);
                    in_data = words[idx];
                    start = poke && (idx == 3);
                    @(negedge clk);
                    acc = in_valid && in_ready;
                    @(posedge clk); #1;
                    start = 1'b0;
                    if (acc) idx++;
                    t++;
                end
                in_valid = 1'b0;
            end
            begin
                cyc = 0;
                while (!saw_done && cyc < budget) begin
                    @(negedge clk);
                    cyc++;
                    if (wr_en) begin
                        nwr++;
                        last_wr = cyc;
                        n_checks++;
                        if (exp_q.size() == 0) begin
                            n_fails++;
                            $display("FAIL extra_write: got addr %0d, required no write",
                                     wr_addr);
                        end else begin
                            e = exp_q.pop_front();
                            if (wr_addr !== e.a || wr_data !== e.d) begin
                                n_fails++;
                                $display("FAIL row_write: got addr %0d data %h, required addr %0d data %h",
                                         wr_addr, wr_data[63:0], e.a, e.d[63:0]);
                            end
                            if (exp_q.size() == 0) begin
                                n_checks++;
                                if (in_ready !== 1'b0) begin
                                    n_fails++;
                                    $display("FAIL ready_after_last: got %b, required 0",
                                             in_ready);
                                end
                            end
                        end
                    end
                    if (done) begin
                        saw_done = 1'b1;
                        n_checks++;
                        if (cyc !== last_wr + 1 || busy !== 1'b0) begin
                            n_fails++;
                            $display("FAIL done_timing: got done cycle %0d busy %b, required cycle %0d busy 0",
                                     cyc, busy, last_wr + 1);
                        end
                    end
                end
            end
        join
        n_checks++;
        if (!saw_done || nwr != rows || exp_q.size() != 0) begin
            n_fails++;
            $display("FAIL load_complete: got done %0b writes %0d, required done 1 writes %0d",
                     saw_done, nwr, rows);
        end
        exp_q.delete();
`ifndef WEIGHT_LOADER_CHECKSUM_EN
        exp_sum = '0;
`endif
        n_checks++;
        if (checksum !== exp_sum) begin
            n_fails++;
            $display("FAIL checksum: got %h, required %h", checksum, exp_sum);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        n_checks++;
        if ({wr_en, done, busy, in_ready} !== 4'b0 || wr_addr !== '0 ||
            wr_data !== '0 || checksum !== '0) begin
            n_fails++;
            $display("FAIL reset_state: got en %b done %b busy %b rdy %b, required all 0",
                     wr_en, done, busy, in_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_load();
        int nwr;
        start = 1'b1;
        num_rows = AW'(2);
        @(posedge clk); #1;
        start = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in_data = DW'(k + 100);
            @(posedge clk); #1;
        end
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if ({wr_en, done, busy, in_ready} !== 4'b0 || wr_addr !== '0 ||
            wr_data !== '0 || checksum !== '0) begin
            n_fails++;
            $display("FAIL reset_mid_load: got en %b done %b busy %b rdy %b sum %h, required all 0",
                     wr_en, done, busy, in_ready, checksum);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        nwr = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (wr_en || done || busy) nwr++;
        end
        in_valid = 1'b0;
        n_checks++;
        if (nwr != 0) begin
            n_fails++;
            $display("FAIL reset_no_write: got %0d active cycles, required 0", nwr);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single_row();
        run_load(1, 0, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_load(2730, 1, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        run_load(3, 1, 50, 1'b0);
        run_load(3, 0, 50, 1'b0);
    endtask

    task automatic test_zero_rows();
        int nwr;
        int done_at;
        in_valid = 1'b1;
        start = 1'b1;
        num_rows = '0;
        @(posedge clk); #1;
        start = 1'b0;
        nwr = 0;
        done_at = -1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (wr_en || in_ready) nwr++;
            if (done) begin
                if (done_at < 0) done_at = c;
                else done_at = 99;
            end
        end
        in_valid = 1'b0;
        n_checks++;
        if (nwr != 0 || done_at != 1) begin
            n_fails++;
            $display("FAIL zero_rows: got writes/ready %0d done at %0d, required 0 and 1",
                     nwr, done_at);
        end
        n_checks++;
        if (checksum !== '0) begin
            n_fails++;
            $display("FAIL zero_rows_sum: got %h, required 0", checksum);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_start_while_busy();
        run_load(2, 1, 20, 1'b1);
    endtask

    task automatic test_checksum();
        run_load(2, 2, 0, 1'b0);
        n_checks++;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
        if (checksum !== 32'hFFFF_FFD0) begin
            n_fails++;
            $display("FAIL checksum_ones: got %h, required ffffffd0", checksum);
        end
`else
        if (checksum !== 32'h0) begin
            n_fails++;
            $display("FAIL checksum_off: got %h, required 0", checksum);
        end
`endif
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
        if (checksum !== 32'hFFFF_FFD0) begin
`else
        if (checksum !== 32'h0) begin
`endif
            n_fails++;
            $display("FAIL checksum_hold: got %h after idle cycles", checksum);
        end
    endtask

    initial begin
        test_reset();
        test_single_row();
        test_reset_mid_load();
        test_single_row();
        test_backpressure();
        test_zero_rows();
        test_start_while_busy();
        test_checksum();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
